// File: rtl/fp_sqrt_pkg.sv
// Shared types and format helpers for the sequential IEEE-754 square-root unit.
// Helpers work on a 64-bit container so any format up to binary64 fits.
package fp_sqrt_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_ROUND,
    ST_DONE
  } sqrt_state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } operand_cls_t;

  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  function automatic logic [MAX_W-1:0] field_mask(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] exp_field(input logic [MAX_W-1:0] x,
                                                 input int unsigned exp_w,
                                                 input int unsigned man_w);
    return (x >> man_w) & field_mask(exp_w);
  endfunction

  function automatic logic [MAX_W-1:0] man_field(input logic [MAX_W-1:0] x,
                                                 input int unsigned man_w);
    return x & field_mask(man_w);
  endfunction

  // Quiet bit position: mantissa MSB
  function automatic logic [MAX_W-1:0] quiet_bit(input int unsigned man_w);
    return MAX_W'(1) << (man_w - 32'd1);
  endfunction

  function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                  input int unsigned man_w);
    return (field_mask(exp_w) << man_w) | quiet_bit(man_w);
  endfunction

  function automatic operand_cls_t classify(input logic [MAX_W-1:0] x,
                                            input int unsigned exp_w,
                                            input int unsigned man_w);
    logic [MAX_W-1:0] e;
    logic [MAX_W-1:0] m;
    operand_cls_t     cls;
    e   = exp_field(x, exp_w, man_w);
    m   = man_field(x, man_w);
    cls = CLS_NORM;
    if (e == '0) begin
      cls = (m == '0) ? CLS_ZERO : CLS_SUB;
    end else if (e == field_mask(exp_w)) begin
      if (m == '0) cls = CLS_INF;
      else if ((m & quiet_bit(man_w)) != '0) cls = CLS_QNAN;
      else cls = CLS_SNAN;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_sqrt_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_sqrt_lzc #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CW-1:0]    lz_o
);

  // Scan upward so the most significant set bit wins
  always_comb begin
    lz_o = CW'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (data_i[i]) lz_o = CW'(int'(WIDTH) - 1 - i);
    end
  end

endmodule

// File: rtl/fp_sqrt_seq.sv
// Sequential IEEE-754 square root: restoring one-bit-per-cycle root with RNE,
// special-operand bypass and valid/ready handshakes on both sides.
module fp_sqrt_seq
  import fp_sqrt_pkg::*;
#(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [1+EXP_W+MAN_W-1:0]   IN_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [1+EXP_W+MAN_W-1:0]   OUT_DATA,
  output logic                       IS_NAN,
  output logic                       IS_PINF,
  output logic                       IS_INVALID
);

  localparam int unsigned W      = 1 + EXP_W + MAN_W;
  localparam int unsigned PW     = EXP_W + MAN_W;
  localparam int unsigned N      = MAN_W + 2;
  localparam int unsigned RW     = MAN_W + 5;
  localparam int unsigned RADW   = 2 * N;
  localparam int unsigned PADW   = N + 2;
  localparam int unsigned LZW    = $clog2(MAN_W + 1);
  localparam int unsigned CW     = $clog2(MAN_W + 1);
  localparam int unsigned EW     = EXP_W + LZW + 2;
  localparam int unsigned BIAS_V = bias(EXP_W);

  sqrt_state_t       state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [W-1:0]      out_data_q;
  logic              is_nan_q;
  logic              is_pinf_q;
  logic              is_invalid_q;
  logic [RW-1:0]     rem_q;
  logic [N-1:0]      root_q;
  logic [RADW-1:0]   rad_q;
  logic [CW-1:0]     cnt_q;
  logic [EXP_W-1:0]  exp_q;

  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;
  logic [MAN_W-1:0]  man_in;
  operand_cls_t      cls_c;
  logic [LZW-1:0]    lz_c;

  assign sign_in = IN_DATA[W-1];
  assign exp_in  = IN_DATA[MAN_W +: EXP_W];
  assign man_in  = IN_DATA[MAN_W-1:0];
  assign cls_c   = classify(MAX_W'(IN_DATA), EXP_W, MAN_W);

  fp_sqrt_lzc #(
    .WIDTH(MAN_W),
    .CW   (LZW)
  ) u_lzc (
    .data_i(man_in),
    .lz_o  (lz_c)
  );

  // Special-operand result and flags, resolved at acceptance
  logic         spec_c;
  logic [W-1:0] spec_data_c;
  logic         spec_nan_c;
  logic         spec_pinf_c;
  logic         spec_inv_c;

  always_comb begin
    spec_c      = 1'b1;
    spec_data_c = IN_DATA;
    spec_nan_c  = 1'b0;
    spec_pinf_c = 1'b0;
    spec_inv_c  = 1'b0;
    case (cls_c)
      CLS_ZERO: spec_c = 1'b1;
      CLS_INF: begin
        if (sign_in) begin
          spec_data_c = W'(canon_qnan(EXP_W, MAN_W));
          spec_nan_c  = 1'b1;
          spec_inv_c  = 1'b1;
        end else begin
          spec_pinf_c = 1'b1;
        end
      end
      CLS_QNAN: spec_nan_c = 1'b1;
      CLS_SNAN: begin
        spec_data_c = IN_DATA | W'(quiet_bit(MAN_W));
        spec_nan_c  = 1'b1;
        spec_inv_c  = 1'b1;
      end
      default: begin
        if (sign_in) begin
          spec_data_c = W'(canon_qnan(EXP_W, MAN_W));
          spec_nan_c  = 1'b1;
          spec_inv_c  = 1'b1;
        end else begin
          spec_c = 1'b0;
        end
      end
    endcase
  end

  // Normalise the operand, make the exponent even and derive the result exponent
  logic [EW-1:0]    e_c;
  logic [MAN_W-1:0] frac_c;
  logic [MAN_W:0]   sig_c;
  logic [N-1:0]     rad_c;
  logic [EXP_W-1:0] exp_res_c;

  always_comb begin
    if (cls_c == CLS_SUB) begin
      e_c    = EW'(0) - EW'(BIAS_V) - EW'(lz_c);
      frac_c = man_in << (lz_c + LZW'(1));
    end else begin
      e_c    = EW'(exp_in) - EW'(BIAS_V);
      frac_c = man_in;
    end
    sig_c     = {1'b1, frac_c};
    rad_c     = e_c[0] ? {sig_c, 1'b0} : {1'b0, sig_c};
    exp_res_c = EXP_W'({e_c[EW-1], e_c[EW-1:1]} + EW'(BIAS_V));
  end

  // One restoring root step
  logic [RW-1:0] rem_sh_c;
  logic [RW-1:0] trial_c;
  logic          ge_c;
  logic [RW-1:0] rem_d;
  logic [N-1:0]  root_d;

  always_comb begin
    rem_sh_c = {rem_q[RW-3:0], rad_q[RADW-1 -: 2]};
    trial_c  = {1'b0, root_q, 2'b01};
    ge_c     = (rem_sh_c >= trial_c);
    rem_d    = ge_c ? (rem_sh_c - trial_c) : rem_sh_c;
    root_d   = {root_q[N-2:0], ge_c};
  end

  // Round to nearest even on the packed exponent/mantissa so carries ripple up
  logic          inc_c;
  logic [PW-1:0] packed_d;

  always_comb begin
    inc_c    = root_q[0] & ((rem_q != '0) | root_q[1]);
    packed_d = {exp_q, root_q[N-2:1]} + PW'(inc_c);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      is_nan_q     <= 1'b0;
      is_pinf_q    <= 1'b0;
      is_invalid_q <= 1'b0;
      rem_q        <= '0;
      root_q       <= '0;
      rad_q        <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (IN_VALID && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (spec_c) begin
              out_data_q   <= spec_data_c;
              is_nan_q     <= spec_nan_c;
              is_pinf_q    <= spec_pinf_c;
              is_invalid_q <= spec_inv_c;
              out_valid_q  <= 1'b1;
              state_q      <= ST_DONE;
            end else begin
              // Leading radicand pair is 01..11, so the first root bit is always 1
              rem_q   <= RW'(rad_c[N-1 -: 2]) - RW'(1);
              root_q  <= N'(1);
              rad_q   <= {rad_c[N-3:0], {PADW{1'b0}}};
              exp_q   <= exp_res_c;
              cnt_q   <= '0;
              state_q <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          rad_q  <= {rad_q[RADW-3:0], 2'b00};
          if (cnt_q == CW'(MAN_W)) begin
            state_q <= ST_ROUND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ROUND: begin
          out_data_q   <= {1'b0, packed_d};
          is_nan_q     <= 1'b0;
          is_pinf_q    <= 1'b0;
          is_invalid_q <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;
  assign IS_NAN     = is_nan_q;
  assign IS_PINF    = is_pinf_q;
  assign IS_INVALID = is_invalid_q;

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Directed bench for fp_sqrt_seq: binary16 and binary32 vector tables plus
// back-pressure and mid-operation reset sequences.
module tb_fp_sqrt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;

  logic        in_valid16, in_ready16, out_valid16;
  logic [15:0] in_data16, out_data16;
  logic        nan16, pinf16, inv16;

  logic        in_valid32, in_ready32, out_valid32;
  logic [31:0] in_data32, out_data32;
  logic        nan32, pinf32, inv32;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_sqrt_seq dut16 (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid16), .IN_READY(in_ready16), .IN_DATA(in_data16),
    .OUT_VALID(out_valid16), .OUT_READY(out_ready), .OUT_DATA(out_data16),
    .IS_NAN(nan16), .IS_PINF(pinf16), .IS_INVALID(inv16)
  );

  fp_sqrt_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid32), .IN_READY(in_ready32), .IN_DATA(in_data32),
    .OUT_VALID(out_valid32), .OUT_READY(out_ready), .OUT_DATA(out_data32),
    .IS_NAN(nan32), .IS_PINF(pinf32), .IS_INVALID(inv32)
  );

  typedef struct {
    bit          b32;
    logic [31:0] op;
    logic [31:0] res;
    logic [2:0]  flg;  // {nan, pinf, invalid}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit b32, input logic [31:0] op, input logic [31:0] res,
                              input logic [2:0] flg, input int lat);
    vec_t v;
    v.b32 = b32; v.op = op; v.res = res; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one operand, measure accept-to-valid latency, then take the result
  task automatic run_op(input bit b32, input logic [31:0] op, output logic [31:0] res,
                        output logic [2:0] flg, output int lat);
    int wait_cnt = 0;
    @(negedge clk);
    while (!(b32 ? in_ready32 : in_ready16) && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (b32) begin in_valid32 = 1'b1; in_data32 = op; end
    else     begin in_valid16 = 1'b1; in_data16 = op[15:0]; end
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_valid32 = 1'b0;
    in_data16  = 16'hA5A5; in_data32 = 32'hDEADBEEF;
    lat = 1;
    while (!(b32 ? out_valid32 : out_valid16) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = b32 ? out_data32 : {16'h0, out_data16};
    flg = b32 ? {nan32, pinf32, inv32} : {nan16, pinf16, inv16};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    logic        saw_valid;

    vecs.push_back(mk(0, 32'h4400, 32'h4000, 3'b000, 13));
    vecs.push_back(mk(0, 32'h4000, 32'h3DA8, 3'b000, 13));
    vecs.push_back(mk(0, 32'h4200, 32'h3EEE, 3'b000, 13));  // sqrt(3) rounds up
    vecs.push_back(mk(0, 32'h3E00, 32'h3CE6, 3'b000, 13));
    vecs.push_back(mk(0, 32'h7BFF, 32'h5BFF, 3'b000, 13));  // just below a tie
    vecs.push_back(mk(0, 32'h0400, 32'h2000, 3'b000, 13));
    vecs.push_back(mk(0, 32'h0001, 32'h0C00, 3'b000, 13));
    vecs.push_back(mk(0, 32'h0200, 32'h1DA8, 3'b000, 13));
    vecs.push_back(mk(0, 32'h03FF, 32'h1FFF, 3'b000, 13));
    vecs.push_back(mk(0, 32'h0000, 32'h0000, 3'b000, 1));
    vecs.push_back(mk(0, 32'h8000, 32'h8000, 3'b000, 1));
    vecs.push_back(mk(0, 32'h7C00, 32'h7C00, 3'b010, 1));
    vecs.push_back(mk(0, 32'h7E00, 32'h7E00, 3'b100, 1));
    vecs.push_back(mk(0, 32'hBC00, 32'h7E00, 3'b101, 1));
    vecs.push_back(mk(0, 32'h8001, 32'h7E00, 3'b101, 1));
    vecs.push_back(mk(0, 32'hFC00, 32'h7E00, 3'b101, 1));
    vecs.push_back(mk(0, 32'h7C01, 32'h7E01, 3'b101, 1));
    vecs.push_back(mk(1, 32'h40800000, 32'h40000000, 3'b000, 26));
    vecs.push_back(mk(1, 32'h40000000, 32'h3FB504F3, 3'b000, 26));
    vecs.push_back(mk(1, 32'h3F800000, 32'h3F800000, 3'b000, 26));
    vecs.push_back(mk(1, 32'hFF800000, 32'h7FC00000, 3'b101, 1));

    rst = 1'b1; out_ready = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0;
    in_valid32 = 1'b0; in_data32 = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready16), 32'd0);
    check("reset out_valid", 32'(out_valid16), 32'd0);
    check("reset out_data", 32'(out_data16), 32'd0);
    check("reset flags", 32'({nan16, pinf16, inv16}), 32'd0);
    check("reset out_valid32", 32'(out_valid32), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready after release", 32'(in_ready16), 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].b32, vecs[i].op, res, flg, lat);
      check($sformatf("vec%0d %0h data", i, vecs[i].op), res, vecs[i].res);
      check($sformatf("vec%0d %0h flags", i, vecs[i].op), 32'(flg), 32'(vecs[i].flg));
      check($sformatf("vec%0d %0h latency", i, vecs[i].op), 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: hold DONE, then a back-to-back operand
    @(negedge clk); in_valid16 = 1'b1; in_data16 = 16'h4400;
    @(posedge clk); #1; in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp latency", 32'(lat), 32'd13);
    in_valid16 = 1'b1; in_data16 = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d data", k), 32'(out_data16), 32'h4000);
      check($sformatf("bp hold%0d in_ready", k), 32'({out_valid16, in_ready16}), 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp handshake out_valid", 32'(out_valid16), 32'd0);
    check("bp handshake in_ready", 32'(in_ready16), 32'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0; in_data16 = 16'hA5A5;
    check("bp back-to-back accepted", 32'(in_ready16), 32'd0);
    lat = 1;
    while (!out_valid16 && lat < 100) begin @(posedge clk); #1; lat++; end
    check("bp second latency", 32'(lat), 32'd13);
    check("bp second data", 32'(out_data16), 32'h3DA8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during ITER abandons the operation
    @(negedge clk); in_valid16 = 1'b1; in_data16 = 16'h4400;
    @(posedge clk); #1; in_valid16 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid16), 32'd0);
    check("midreset in_ready", 32'(in_ready16), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midreset in_ready after release", 32'(in_ready16), 32'd1);
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid16) saw_valid = 1'b1;
    end
    check("midreset no stale output", 32'(saw_valid), 32'd0);
    run_op(1'b0, 32'h3C00, res, flg, lat);
    check("post-reset data", res, 32'h3C00);
    check("post-reset flags", 32'(flg), 32'd0);
    check("post-reset latency", 32'(lat), 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
